// File: rtl/fetch_module_pkg.sv
// Shared types and constants for the fetch front end.
package fetch_module_pkg;

    localparam int INSN_SIZE = 32;
    localparam int PC_SIZE   = 64;
    localparam logic [INSN_SIZE-1:0] HLT_ENCODING = 32'hD440_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_RUN,
        FETCH_HALT_PEND,
        FETCH_HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [INSN_SIZE-1:0] insn;
        logic [PC_SIZE-1:0]   pc;
    } fq_entry_t;

    function automatic logic is_hlt(input logic [INSN_SIZE-1:0] word);
        return word == HLT_ENCODING;
    endfunction

endpackage

// File: rtl/fetch_module_if.sv
// Fetch-unit bundle: control from the core, instruction-memory port and dispatch port.
interface fetch_module_if #(
    parameter int IMEM_AW = 10
) ();
    import fetch_module_pkg::*;

    logic                 in_start;
    logic                 in_stall;
    logic                 in_redirect;
    logic [PC_SIZE-1:0]   in_redirect_pc;
    logic                 out_imem_req;
    logic [IMEM_AW-1:0]   out_imem_addr;
    logic [INSN_SIZE-1:0] in_imem_data;
    logic [INSN_SIZE-1:0] out_insnbits;
    logic [PC_SIZE-1:0]   out_pc;
    logic                 out_fetch_done;
    logic                 out_halted;

    modport master (
        input  in_start, in_stall, in_redirect, in_redirect_pc, in_imem_data,
        output out_imem_req, out_imem_addr, out_insnbits, out_pc, out_fetch_done, out_halted
    );

    modport slave (
        output in_start, in_stall, in_redirect, in_redirect_pc, in_imem_data,
        input  out_imem_req, out_imem_addr, out_insnbits, out_pc, out_fetch_done, out_halted
    );

endinterface

// File: rtl/fetch_module_queue.sv
// Circular fetch queue of {insn, pc}; flush wins over push/pop in the same cycle.
module fetch_queue
    import fetch_module_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fq_entry_t     push_data,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output fq_entry_t     head,
    output logic [CW-1:0] count
);

    fq_entry_t     entries [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = entries[head_ptr];

    // A push into a full queue is still legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                tail_ptr <= tail_ptr + PW'(1);
            end
            if (do_pop) begin
                head_ptr <= head_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            entries[tail_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_module.sv
// Instruction fetch: PC, one-deep memory read pipeline, epoch tagging and halt sequencing.
module fetch_module
    import fetch_module_pkg::*;
#(
    parameter int                 FQ_DEPTH = 4,
    parameter int                 IMEM_AW  = 10,
    parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
    input  logic           in_clk,
    input  logic           in_rst,
    fetch_module_if.master bus
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_t       state;
    fetch_state_t       state_next;
    logic [PC_SIZE-1:0] pc;
    logic               epoch;
    logic               inflight;
    logic               inflight_epoch;
    logic [PC_SIZE-1:0] inflight_pc;

    logic               redirect_ok;
    logic               resp_valid;
    logic               resp_hlt;
    logic               has_room;
    logic               issue;

    logic               q_push;
    logic               q_pop;
    logic               q_full;
    logic               q_empty;
    fq_entry_t          q_head;
    fq_entry_t          q_push_data;
    logic [CW-1:0]      q_count;

    assign redirect_ok = bus.in_redirect && (state != FETCH_IDLE);
    assign resp_valid  = inflight && (inflight_epoch == epoch);
    assign resp_hlt    = resp_valid && is_hlt(bus.in_imem_data);
    assign has_room    = !q_full && ((int'(q_count) + int'(inflight)) < FQ_DEPTH);

    assign q_push_data.insn = bus.in_imem_data;
    assign q_push_data.pc   = inflight_pc;
    assign q_push = resp_valid && !redirect_ok;
    assign q_pop  = !q_empty && !bus.in_stall && !redirect_ok;

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk       (in_clk),
        .rst_n     (in_rst),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (redirect_ok),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head),
        .count     (q_count)
    );

    // The word after HLT is never requested, so the issue is held off in the cycle HLT returns.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            FETCH_IDLE: begin
                if (bus.in_start) begin
                    state_next = FETCH_RUN;
                end
            end
            FETCH_RUN: begin
                issue = has_room && !redirect_ok && !resp_hlt;
                if (redirect_ok) begin
                    state_next = FETCH_RUN;
                end else if (resp_hlt) begin
                    state_next = FETCH_HALT_PEND;
                end
            end
            FETCH_HALT_PEND: begin
                if (redirect_ok) begin
                    state_next = FETCH_RUN;
                end else if (q_empty && !inflight) begin
                    state_next = FETCH_HALTED;
                end
            end
            FETCH_HALTED: begin
                if (redirect_ok) begin
                    state_next = FETCH_RUN;
                end
            end
            default: begin
                state_next = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state          <= FETCH_IDLE;
            pc             <= RESET_PC;
            epoch          <= 1'b0;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_pc    <= '0;
        end else begin
            state <= state_next;
            if (redirect_ok) begin
                pc       <= bus.in_redirect_pc & ~PC_SIZE'(3);
                epoch    <= ~epoch;
                inflight <= 1'b0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    pc             <= pc + PC_SIZE'(4);
                    inflight_pc    <= pc;
                    inflight_epoch <= epoch;
                end
            end
        end
    end

    assign bus.out_imem_req   = issue;
    assign bus.out_imem_addr  = issue ? pc[IMEM_AW+1:2] : '0;
    assign bus.out_fetch_done = !q_empty;
    assign bus.out_insnbits   = q_empty ? '0 : q_head.insn;
    assign bus.out_pc         = q_empty ? '0 : q_head.pc;
    assign bus.out_halted     = (state == FETCH_HALTED);

endmodule

// File: tb/tb_fetch_module.sv
// Bench for fetch_module: directed latency/stall/redirect/halt/reset cases plus a random run
// scored against an in-order delivery model of the program stream.
module tb_fetch_module;
    import fetch_module_pkg::*;

    localparam int AW = 10;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] FIRST_WORD = 32'h8B02_0020;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_module_if #(.IMEM_AW(AW)) bus ();
    fetch_module_if #(.IMEM_AW(AW)) wbus ();

    fetch_module #(.FQ_DEPTH(4), .IMEM_AW(AW), .RESET_PC(64'h0)) dut (
        .in_clk (clk),
        .in_rst (rst_n),
        .bus    (bus)
    );

    fetch_module #(.FQ_DEPTH(4), .IMEM_AW(AW), .RESET_PC(WRAP_PC)) dut_wrap (
        .in_clk (clk),
        .in_rst (rst_n),
        .bus    (wbus)
    );

    logic [31:0] imem [1024];

    // Synchronous instruction memory shared by both instances.
    always @(posedge clk) begin
        if (bus.out_imem_req) bus.in_imem_data <= imem[bus.out_imem_addr];
        if (wbus.out_imem_req) wbus.in_imem_data <= imem[wbus.out_imem_addr];
    end

    int compared = 0;
    int mismatched = 0;
    int req_count = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_imem_req) req_count++;
    end

    // Delivery model: the program is consumed strictly in order from exp_pc, restarting at the
    // redirect target and ending after the HLT word.
    logic        sb_on = 1'b0;
    logic [63:0] exp_pc = '0;
    logic        halt_seen = 1'b0;
    logic        prev_redir = 1'b0;
    int          delivered = 0;

    always @(negedge clk) begin
        if (sb_on && rst_n) begin
            if (bus.in_redirect) begin
                exp_pc = bus.in_redirect_pc & ~64'h3;
                halt_seen = 1'b0;
                prev_redir = 1'b1;
            end else begin
                if (prev_redir) begin
                    checkOutput("post_redir_done", 64'(bus.out_fetch_done), 64'd0);
                    checkOutput("post_redir_req", 64'(bus.out_imem_req), 64'd1);
                    checkOutput("post_redir_addr", 64'(bus.out_imem_addr), 64'(exp_pc[AW+1:2]));
                end
                if (halt_seen) begin
                    checkOutput("post_hlt_req", 64'(bus.out_imem_req), 64'd0);
                    checkOutput("post_hlt_done", 64'(bus.out_fetch_done), 64'd0);
                end
                if (bus.out_fetch_done && !bus.in_stall) begin
                    checkOutput("dlv_pc", bus.out_pc, exp_pc);
                    checkOutput("dlv_insn", 64'(bus.out_insnbits), 64'(imem[exp_pc[AW+1:2]]));
                    if (imem[exp_pc[AW+1:2]] == HLT_ENCODING) halt_seen = 1'b1;
                    exp_pc = exp_pc + 64'd4;
                    delivered++;
                end
                prev_redir = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic stall, input logic redirect,
                                 input logic [63:0] rpc);
        bus.in_start = start;
        bus.in_stall = stall;
        bus.in_redirect = redirect;
        bus.in_redirect_pc = rpc;
    endtask

    task automatic doReset();
        sb_on = 1'b0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_pc = '0;
        halt_seen = 1'b0;
        prev_redir = 1'b0;
        delivered = 0;
        req_count = 0;
        sb_on = 1'b1;
    endtask

    task automatic waitDone(input string tag, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.out_fetch_done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checkOutput(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w;
        bit          halted_ok;

        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            while (w == HLT_ENCODING) w = $urandom;
            imem[i] = w;
        end
        imem[0] = FIRST_WORD;
        bus.in_imem_data = '0;
        wbus.in_imem_data = '0;
        wbus.in_start = 1'b0;
        wbus.in_stall = 1'b0;
        wbus.in_redirect = 1'b0;
        wbus.in_redirect_pc = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);

        // Reset values.
        repeat (2) @(negedge clk);
        checkOutput("rst_req", 64'(bus.out_imem_req), 64'd0);
        checkOutput("rst_addr", 64'(bus.out_imem_addr), 64'd0);
        checkOutput("rst_insn", 64'(bus.out_insnbits), 64'd0);
        checkOutput("rst_pc", bus.out_pc, 64'd0);
        checkOutput("rst_done", 64'(bus.out_fetch_done), 64'd0);
        checkOutput("rst_halted", 64'(bus.out_halted), 64'd0);

        // First-instruction latency and back-to-back delivery.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("c0_req", 64'(bus.out_imem_req), 64'd0);
        tick();
        @(negedge clk);
        checkOutput("c1_req", 64'(bus.out_imem_req), 64'd1);
        checkOutput("c1_addr", 64'(bus.out_imem_addr), 64'd0);
        checkOutput("c1_done", 64'(bus.out_fetch_done), 64'd0);
        tick();
        @(negedge clk);
        checkOutput("c2_done", 64'(bus.out_fetch_done), 64'd0);
        tick();
        @(negedge clk);
        checkOutput("c3_done", 64'(bus.out_fetch_done), 64'd1);
        checkOutput("c3_insn", 64'(bus.out_insnbits), 64'(FIRST_WORD));
        checkOutput("c3_pc", bus.out_pc, 64'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            @(negedge clk);
            checkOutput("seq_done", 64'(bus.out_fetch_done), 64'd1);
            checkOutput("seq_pc", bus.out_pc, 64'(4 * i));
        end

        // Ten stalled cycles: queue fills to exactly four words, then drains without gaps.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        tick();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
        repeat (9) tick();
        @(negedge clk);
        checkOutput("stall_reqs", 64'(req_count), 64'd4);
        checkOutput("stall_req_now", 64'(bus.out_imem_req), 64'd0);
        checkOutput("stall_head_pc", bus.out_pc, 64'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("drain_done", 64'(bus.out_fetch_done), 64'd1);
            checkOutput("drain_pc", bus.out_pc, 64'(4 * i));
            tick();
        end

        // Redirect with a read in flight and a non-empty queue.
        @(negedge clk);
        checkOutput("redir_pre_req", 64'(bus.out_imem_req), 64'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h1003);
        @(negedge clk);
        checkOutput("redir_cycle_done", 64'(bus.out_fetch_done), 64'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        waitDone("redir_wait", 10);
        checkOutput("redir_first_pc", bus.out_pc, 64'h1000);
        tick();

        // Random stalls and redirects against the delivery model.
        delivered = 0;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b1, ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 4),
                          {$urandom, $urandom});
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        repeat (8) tick();
        checkOutput("rand_progress", 64'(delivered > 100), 64'd1);

        // HLT at word 3, then redirect out of HALTED.
        imem[3] = HLT_ENCODING;
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        halted_ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_halted) begin
                halted_ok = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("hlt_halted", 64'(halted_ok), 64'd1);
        checkOutput("hlt_delivered", 64'(delivered), 64'd4);
        checkOutput("hlt_reqs", 64'(req_count), 64'd4);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h40);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("hlt_unhalt", 64'(bus.out_halted), 64'd0);
        tick();
        waitDone("hlt_redir_wait", 10);
        checkOutput("hlt_redir_pc", bus.out_pc, 64'h40);
        tick();
        imem[3] = 32'h1234_5678;

        // Asynchronous reset with the queue full, then restart.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
        repeat (10) tick();
        @(negedge clk);
        checkOutput("full_done", 64'(bus.out_fetch_done), 64'd1);
        checkOutput("full_req", 64'(bus.out_imem_req), 64'd0);
        tick();
        sb_on = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_done", 64'(bus.out_fetch_done), 64'd0);
        checkOutput("arst_insn", 64'(bus.out_insnbits), 64'd0);
        checkOutput("arst_pc", bus.out_pc, 64'd0);
        checkOutput("arst_req", 64'(bus.out_imem_req), 64'd0);
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        tick();
        tick();
        tick();
        @(negedge clk);
        checkOutput("restart_done", 64'(bus.out_fetch_done), 64'd1);
        checkOutput("restart_pc", bus.out_pc, 64'd0);
        checkOutput("restart_insn", 64'(bus.out_insnbits), 64'(imem[0]));

        // PC and word-address wrap on the second instance.
        tick();
        wbus.in_start = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("wrap_req0", 64'(wbus.out_imem_req), 64'd1);
        checkOutput("wrap_addr0", 64'(wbus.out_imem_addr), 64'd1023);
        tick();
        @(negedge clk);
        checkOutput("wrap_addr1", 64'(wbus.out_imem_addr), 64'd0);
        tick();
        @(negedge clk);
        checkOutput("wrap_first_pc", wbus.out_pc, WRAP_PC);
        checkOutput("wrap_first_insn", 64'(wbus.out_insnbits), 64'(imem[1023]));
        tick();
        @(negedge clk);
        checkOutput("wrap_next_pc", wbus.out_pc, 64'd0);
        checkOutput("wrap_next_insn", 64'(wbus.out_insnbits), 64'(imem[0]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
